// File: rtl/mfp_ahb_sevenseg_scanner.sv
// Eight-digit seven-segment scan driver with frame-synchronous double buffering.
// Optional blink support is enabled by defining SEVENSEG_BLINK_EN.
module mfp_ahb_sevenseg_scanner #(
  parameter int unsigned SCAN_DIV     = 4096,
  parameter int unsigned BLANK_CYC    = 16,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        wr_en,
  input  logic [2:0]  wr_sel,
  input  logic [31:0] wr_data,
  output logic [5:0]  code,
  output logic [7:0]  anode,
  output logic [2:0]  digit_idx,
  output logic        frame_done
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DIG_W = 5;

  // One complete display image; pending and active copies share this layout.
  typedef struct packed {
`ifdef SEVENSEG_BLINK_EN
    logic [7:0]            blink;
`endif
    logic [7:0]            en;
    logic [7:0]            dp;
    logic [7:0][DIG_W-1:0] dig;
  } regs_t;

  regs_t            pend_q, pend_d;
  regs_t            act_q, act_d;
  logic [CNT_W-1:0] slot_q, slot_d;
  logic [2:0]       idx_q, idx_d;
  logic [5:0]       code_q, code_d;
  logic [7:0]       anode_q, anode_d;
  logic             frame_done_q, frame_done_d;
  logic             slot_wrap_c;
  logic             commit_c;
  logic             lit_c;
  logic             unused_wr_data_c;

`ifdef SEVENSEG_BLINK_EN
  localparam int unsigned FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FC_W-1:0] fcnt_q, fcnt_d;
  logic            phase_q, phase_d;
`else
  localparam int unsigned unused_blink_frames_c = BLINK_FRAMES;
`endif

  assign unused_wr_data_c = ^wr_data[31:20];

  // Next-state logic: register writes, scan counters, commit and output image.
  always_comb begin
    pend_d       = pend_q;
    act_d        = act_q;
    slot_d       = slot_q;
    idx_d        = idx_q;
    frame_done_d = 1'b0;
    code_d       = code_q;
    anode_d      = 8'hFF;
    lit_c        = 1'b0;
    slot_wrap_c  = 1'b0;
    commit_c     = 1'b0;
`ifdef SEVENSEG_BLINK_EN
    fcnt_d       = fcnt_q;
    phase_d      = phase_q;
`endif

    if (wr_en) begin
      case (wr_sel)
        3'd0: pend_d.en = wr_data[7:0];
        3'd1: begin
          pend_d.dig[0] = wr_data[4:0];
          pend_d.dig[1] = wr_data[9:5];
          pend_d.dig[2] = wr_data[14:10];
          pend_d.dig[3] = wr_data[19:15];
        end
        3'd2: begin
          pend_d.dig[4] = wr_data[4:0];
          pend_d.dig[5] = wr_data[9:5];
          pend_d.dig[6] = wr_data[14:10];
          pend_d.dig[7] = wr_data[19:15];
        end
        3'd3: pend_d.dp = wr_data[7:0];
`ifdef SEVENSEG_BLINK_EN
        3'd4: pend_d.blink = wr_data[7:0];
`endif
        default: ;
      endcase
    end

    slot_wrap_c = (slot_q == CNT_W'(SCAN_DIV - 1));
    slot_d      = slot_wrap_c ? '0 : slot_q + CNT_W'(1);
    idx_d       = slot_wrap_c ? idx_q + 3'd1 : idx_q;
    commit_c    = slot_wrap_c && (idx_q == 3'd7);

    // Commit copies the pre-edge pending image; a same-edge write lands next frame.
    if (commit_c) begin
      act_d = pend_q;
    end
    frame_done_d = commit_c;

`ifdef SEVENSEG_BLINK_EN
    if (commit_c) begin
      if (fcnt_q == FC_W'(BLINK_FRAMES - 1)) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d  = fcnt_q + FC_W'(1);
      end
    end
`endif

    // Outputs track the next-state slot so code changes during blanking.
    code_d = {~act_d.dp[idx_d], act_d.dig[idx_d]};
    lit_c  = act_d.en[idx_d];
`ifdef SEVENSEG_BLINK_EN
    if (phase_d && act_d.blink[idx_d]) begin
      lit_c = 1'b0;
    end
`endif
    if ((slot_d >= CNT_W'(BLANK_CYC)) && lit_c) begin
      anode_d = ~(8'd1 << idx_d);
    end
  end

  // State and output registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend_q       <= '0;
      act_q        <= '0;
      slot_q       <= '0;
      idx_q        <= 3'd0;
      code_q       <= 6'b100000;
      anode_q      <= 8'hFF;
      frame_done_q <= 1'b0;
`ifdef SEVENSEG_BLINK_EN
      fcnt_q       <= '0;
      phase_q      <= 1'b0;
`endif
    end else begin
      pend_q       <= pend_d;
      act_q        <= act_d;
      slot_q       <= slot_d;
      idx_q        <= idx_d;
      code_q       <= code_d;
      anode_q      <= anode_d;
      frame_done_q <= frame_done_d;
`ifdef SEVENSEG_BLINK_EN
      fcnt_q       <= fcnt_d;
      phase_q      <= phase_d;
`endif
    end
  end

  assign code       = code_q;
  assign anode      = anode_q;
  assign digit_idx  = idx_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_mfp_ahb_sevenseg_scanner.sv
// Directed self-checking bench for mfp_ahb_sevenseg_scanner (SCAN_DIV=8, BLANK_CYC=2).
module tb_mfp_ahb_sevenseg_scanner;

  logic        HCLK;
  logic        HRESETn;
  logic        wr_en;
  logic [2:0]  wr_sel;
  logic [31:0] wr_data;
  logic [5:0]  code;
  logic [7:0]  anode;
  logic [2:0]  digit_idx;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

`ifdef SEVENSEG_BLINK_EN
  localparam int SEL4_CYC = -1;
`else
  localparam int SEL4_CYC = 10;
`endif

  logic [7:0][5:0] codes_z;
  logic [7:0][5:0] codes_a;
  logic [7:0][5:0] codes_b;

  mfp_ahb_sevenseg_scanner #(
    .SCAN_DIV     (8),
    .BLANK_CYC    (2),
    .BLINK_FRAMES (2)
  ) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .wr_data    (wr_data),
    .code       (code),
    .anode      (anode),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wr(input logic [2:0] sel, input logic [31:0] data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_data = data;
    @(negedge HCLK);
    wr_en   = 1'b0;
  endtask

  task automatic wait_frame_done();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge HCLK);
      if (frame_done) begin
        found = 1'b1;
        break;
      end
    end
    chk("fd_wait", 32'(found), 32'd1);
  endtask

  // Checks one 64-cycle frame starting at slot 0 count 0; optionally issues one write.
  task automatic run_frame(input logic [7:0] en, input logic [7:0][5:0] codes,
                           input int wr_cyc, input logic [2:0] sel,
                           input logic [31:0] data, input bit fd0);
    logic [2:0] ix;
    logic [7:0] exp_an;
    for (int c = 0; c < 64; c++) begin
      ix     = 3'(c / 8);
      exp_an = 8'hFF;
      if ((c % 8) >= 2 && en[ix]) exp_an = ~(8'd1 << ix);
      chk("anode", 32'(anode), 32'(exp_an));
      chk("code", 32'(code), 32'(codes[ix]));
      chk("idx", 32'(digit_idx), 32'(ix));
      chk("fdone", 32'(frame_done), 32'((c == 0) && fd0));
      wr_en   = (c == wr_cyc);
      wr_sel  = sel;
      wr_data = data;
      @(negedge HCLK);
    end
    wr_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    codes_z = {8{6'h20}};
    codes_a = {6'h20, 6'h20, 6'h20, 6'h20, 6'h21, 6'h22, 6'h23, 6'h04};
    codes_b = {6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h21, 6'h22, 6'h23, 6'h04};
    HRESETn = 1'b0;
    wr_en   = 1'b0;
    wr_sel  = 3'd0;
    wr_data = 32'd0;

    repeat (3) @(negedge HCLK);
    chk("rst_anode", 32'(anode), 32'hFF);
    chk("rst_code", 32'(code), 32'h20);
    chk("rst_idx", 32'(digit_idx), 32'd0);
    chk("rst_fdone", 32'(frame_done), 32'd0);
    HRESETn = 1'b1;

    // EN=0 after reset: no anode ever goes low
    run_frame(8'h00, codes_z, -1, 3'd0, 32'd0, 1'b0);

    // EN=FF, digits 3..0 = 1,2,3,4, DP=01
    wr(3'd0, 32'h0000_00FF);
    wr(3'd1, 32'h0000_8864);
    wr(3'd3, 32'h0000_0001);
    wait_frame_done();

    // Mid-frame write to digits 7..4 stays pending for this frame
    run_frame(8'hFF, codes_a, 20, 3'd2, 32'h000F_FFFF, 1'b1);
    // New digits visible; EN=00 written on the commit edge
    run_frame(8'hFF, codes_b, 63, 3'd0, 32'h0000_0000, 1'b1);
    // Old EN still active for one more frame
    run_frame(8'hFF, codes_b, -1, 3'd0, 32'd0, 1'b1);
    // EN=00 now: all dark; stage EN=A5
    run_frame(8'h00, codes_b, 10, 3'd0, 32'h0000_00A5, 1'b1);
    // Sparse enable; write to an unused select
    run_frame(8'hA5, codes_b, 5, 3'd5, 32'hFFFF_FFFF, 1'b1);
    // Unused select had no effect; BLINK write ignored when blink is absent
    run_frame(8'hA5, codes_b, SEL4_CYC, 3'd4, 32'h0000_00FF, 1'b1);
    run_frame(8'hA5, codes_b, -1, 3'd0, 32'd0, 1'b1);

    // Asynchronous reset in the lit part of slot 2
    repeat (20) @(negedge HCLK);
    chk("pre_rst_anode", 32'(anode), 32'hFB);
    #3 HRESETn = 1'b0;
    #1;
    chk("arst_anode", 32'(anode), 32'hFF);
    chk("arst_code", 32'(code), 32'h20);
    chk("arst_idx", 32'(digit_idx), 32'd0);
    chk("arst_fdone", 32'(frame_done), 32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Pending contents were lost by reset
    run_frame(8'h00, codes_z, -1, 3'd0, 32'd0, 1'b0);
    run_frame(8'h00, codes_z, -1, 3'd0, 32'd0, 1'b1);

`ifdef SEVENSEG_BLINK_EN
    // BLINK=01 committed while phase is 1: dark, dark, lit, lit, dark
    wr(3'd0, 32'h0000_00FF);
    wr(3'd4, 32'h0000_0001);
    wait_frame_done();
    run_frame(8'hFE, codes_z, -1, 3'd0, 32'd0, 1'b1);
    run_frame(8'hFF, codes_z, -1, 3'd0, 32'd0, 1'b1);
    run_frame(8'hFF, codes_z, -1, 3'd0, 32'd0, 1'b1);
    run_frame(8'hFE, codes_z, -1, 3'd0, 32'd0, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
